// File: rtl/sys_array_feeder.sv
// ============================================================================
// Module   : sys_array_feeder
// Brief    : Buffers A/B operands and feeds a systolic array with diagonal skew.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sys_array_feeder #(
   parameter int N  = 2,
   parameter int K  = 4,
   parameter int DW = 32
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     ld_en,
   input  logic                     ld_sel,
   input  logic [$clog2(N)-1:0]     ld_idx,
   input  logic [$clog2(K)-1:0]     ld_k,
   input  logic [DW-1:0]            ld_data,
   input  logic [$clog2(K+1)-1:0]   k_len,
   input  logic                     start,
   input  logic                     stall,
   output logic [N*DW-1:0]          row_data,
   output logic [N-1:0]             row_valid,
   output logic [N*DW-1:0]          col_data,
   output logic [N-1:0]             col_valid,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int c_TW = $clog2(K+N);
   localparam int c_KW = $clog2(K);
   localparam int c_LW = $clog2(K+1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FEED = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [c_TW-1:0]   r_t;
   logic [c_LW-1:0]   r_klen;
   logic [DW-1:0]     r_a [N][K];
   logic [DW-1:0]     r_b [N][K];

   logic [N-1:0]      w_v;
   logic [N*DW-1:0]   w_rd;
   logic [N*DW-1:0]   w_cd;
   logic              w_last;
   logic              w_bad_len;

   // Operand storage carries no reset; contents are only meaningful once loaded.
   always_ff @(posedge CLK) begin
      if (ld_en && !busy && (32'(ld_idx) < N) && (32'(ld_k) < K)) begin
         if (ld_sel)
            r_b[ld_idx][ld_k] <= ld_data;
         else
            r_a[ld_idx][ld_k] <= ld_data;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [c_TW-1:0] w_off;
      assign w_off    = r_t - c_TW'(i);
      assign w_v[i]   = (r_t >= c_TW'(i)) && (w_off < c_TW'(r_klen));
      assign w_rd[i*DW +: DW] = w_v[i] ? r_a[i][w_off[c_KW-1:0]] : '0;
      assign w_cd[i*DW +: DW] = w_v[i] ? r_b[i][w_off[c_KW-1:0]] : '0;
   end

   assign w_last    = (r_t == (c_TW'(r_klen) + c_TW'(N-2)));
   assign w_bad_len = (k_len == '0) || (k_len > c_LW'(K));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_t       <= '0;
         r_klen    <= '0;
         row_data  <= '0;
         row_valid <= '0;
         col_data  <= '0;
         col_valid <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_bad_len) begin
                     err <= 1'b1;
                  end else begin
                     r_klen  <= k_len;
                     r_t     <= '0;
                     err     <= 1'b0;
                     busy    <= 1'b1;
                     r_state <= S_FEED;
                  end
               end
            end
            S_FEED: begin
               if (!stall) begin
                  row_valid <= w_v;
                  col_valid <= w_v;
                  row_data  <= w_rd;
                  col_data  <= w_cd;
                  r_t       <= r_t + c_TW'(1);
                  if (w_last)
                     r_state <= S_DONE;
               end
            end
            S_DONE: begin
               // Back-pressure no longer matters: every operand is already issued.
               row_valid <= '0;
               col_valid <= '0;
               row_data  <= '0;
               col_data  <= '0;
               done      <= 1'b1;
               busy      <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sys_array_feeder.sv
// ============================================================================
// Module   : tb_sys_array_feeder
// Brief    : Scoreboard bench for sys_array_feeder (N=2, K=4, DW=32).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sys_array_feeder;

   localparam int N  = 2;
   localparam int K  = 4;
   localparam int DW = 32;

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic            ld_en = 1'b0;
   logic            ld_sel = 1'b0;
   logic [0:0]      ld_idx = '0;
   logic [1:0]      ld_k = '0;
   logic [DW-1:0]   ld_data = '0;
   logic [2:0]      k_len = '0;
   logic            start = 1'b0;
   logic            stall = 1'b0;
   logic [N*DW-1:0] row_data;
   logic [N-1:0]    row_valid;
   logic [N*DW-1:0] col_data;
   logic [N-1:0]    col_valid;
   logic            busy;
   logic            done;
   logic            err;

   sys_array_feeder #(.N(N), .K(K), .DW(DW)) dut (
      .CLK(CLK), .RST(RST), .ld_en(ld_en), .ld_sel(ld_sel), .ld_idx(ld_idx),
      .ld_k(ld_k), .ld_data(ld_data), .k_len(k_len), .start(start), .stall(stall),
      .row_data(row_data), .row_valid(row_valid), .col_data(col_data),
      .col_valid(col_valid), .busy(busy), .done(done), .err(err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic            stl;
      logic            poke;
      logic [N-1:0]    rv;
      logic [N*DW-1:0] rd;
      logic [N-1:0]    cv;
      logic [N*DW-1:0] cd;
      logic            bsy;
      logic            dn;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] ma [N][K];
   logic [DW-1:0] mb [N][K];
   int            n_tests = 0;
   int            n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, " row_valid"}, 64'(row_valid), 64'(0));
      check({tag, " col_valid"}, 64'(col_valid), 64'(0));
      check({tag, " row_data"},  row_data, 64'(0));
      check({tag, " col_data"},  col_data, 64'(0));
      check({tag, " busy"},      64'(busy), 64'(0));
      check({tag, " done"},      64'(done), 64'(0));
   endtask

   task automatic load(input logic sel, input int idx, input int k, input logic [DW-1:0] d);
      @(negedge CLK);
      ld_en = 1'b1; ld_sel = sel; ld_idx = idx[0:0]; ld_k = k[1:0]; ld_data = d;
      if (sel) mb[idx][k] = d; else ma[idx][k] = d;
      @(negedge CLK);
      ld_en = 1'b0;
   endtask

   // Expected edge outputs for skew slot t, derived from the bench's buffer model.
   function automatic exp_t slot(input int t, input int klen);
      exp_t e;
      e.stl = 1'b0; e.poke = 1'b0; e.bsy = 1'b1; e.dn = 1'b0;
      e.rv = '0; e.cv = '0; e.rd = '0; e.cd = '0;
      for (int i = 0; i < N; i++) begin
         if (t >= i && (t - i) < klen) begin
            e.rv[i] = 1'b1;
            e.cv[i] = 1'b1;
            e.rd[i*DW +: DW] = ma[i][t-i];
            e.cd[i*DW +: DW] = mb[i][t-i];
         end
      end
      return e;
   endfunction

   task automatic run(input int klen, input int stall_slot, input int stall_n,
                      input bit poke, input bit wr, input logic [DW-1:0] wd,
                      input int abort);
      exp_t e;
      int   popped = 0;
      bit   aborted = 0;
      @(negedge CLK);
      start = 1'b1; k_len = klen[2:0];
      if (wr) begin
         ld_en = 1'b1; ld_sel = 1'b0; ld_idx = 1'b1; ld_k = 2'd0; ld_data = wd;
         ma[1][0] = wd;
      end
      for (int t = 0; t <= klen + N - 2; t++) begin
         e = slot(t, klen);
         if (poke && t == 1) e.poke = 1'b1;
         sb.push_back(e);
         if (t == stall_slot) begin
            e.poke = 1'b0;
            e.stl  = 1'b1;
            for (int s = 0; s < stall_n; s++) sb.push_back(e);
         end
      end
      e = slot(-N - K, klen);
      e.bsy = 1'b0; e.dn = 1'b1; e.stl = (stall_n > 0);
      sb.push_back(e);
      e.dn = 1'b0; e.stl = 1'b0;
      sb.push_back(e);
      @(negedge CLK);
      start = 1'b0; ld_en = 1'b0;
      while (sb.size() > 0 && !aborted) begin
         e = sb.pop_front();
         stall = e.stl;
         if (e.poke) begin
            start = 1'b1; k_len = 3'd1;
            ld_en = 1'b1; ld_sel = 1'b0; ld_idx = 1'b0; ld_k = 2'd0; ld_data = 32'hDEADBEEF;
         end
         @(posedge CLK);
         #1;
         check($sformatf("k%0d e%0d row_valid", klen, popped), 64'(row_valid), 64'(e.rv));
         check($sformatf("k%0d e%0d col_valid", klen, popped), 64'(col_valid), 64'(e.cv));
         check($sformatf("k%0d e%0d row_data", klen, popped), row_data, e.rd);
         check($sformatf("k%0d e%0d col_data", klen, popped), col_data, e.cd);
         check($sformatf("k%0d e%0d busy", klen, popped), 64'(busy), 64'(e.bsy));
         check($sformatf("k%0d e%0d done", klen, popped), 64'(done), 64'(e.dn));
         check($sformatf("k%0d e%0d err", klen, popped), 64'(err), 64'(0));
         popped++;
         if (popped == abort) begin
            #2 RST = 1'b1;
            #1 check_idle_zero("async reset");
            sb.delete();
            @(posedge CLK);
            #1 check_idle_zero("reset held");
            @(negedge CLK);
            RST = 1'b0;
            stall = 1'b0;
            aborted = 1;
         end else begin
            @(negedge CLK);
            start = 1'b0; ld_en = 1'b0; stall = 1'b0;
         end
      end
   endtask

   task automatic bad_start(input int klen);
      @(negedge CLK);
      start = 1'b1; k_len = klen[2:0];
      @(posedge CLK);
      #1;
      check($sformatf("bad k%0d err", klen), 64'(err), 64'(1));
      check($sformatf("bad k%0d busy", klen), 64'(busy), 64'(0));
      check($sformatf("bad k%0d row_valid", klen), 64'(row_valid), 64'(0));
      @(negedge CLK);
      start = 1'b0;
      @(posedge CLK);
      #1;
      check($sformatf("bad k%0d stays idle", klen), 64'(busy), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge CLK);
      #1;
      check_idle_zero("reset");
      check("reset err", 64'(err), 64'(0));
      @(negedge CLK);
      RST = 1'b0;

      for (int k = 0; k < K; k++) begin
         logic [DW-1:0] a0 [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
         logic [DW-1:0] a1 [4] = '{32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
         logic [DW-1:0] b0 [4] = '{32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};
         logic [DW-1:0] b1 [4] = '{32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
         load(1'b0, 0, k, a0[k]);
         load(1'b0, 1, k, a1[k]);
         load(1'b1, 0, k, b0[k]);
         load(1'b1, 1, k, b1[k]);
      end

      // full depth, unstalled
      run(4, -1, 0, 1'b0, 1'b0, '0, -1);
      // depth 1 with a same-cycle write to A[1][0]
      run(1, -1, 0, 1'b0, 1'b1, 32'h3FC00000, -1);
      // three-cycle stall at slot 2, plus ignored start/write while busy
      run(4, 2, 3, 1'b1, 1'b0, '0, -1);
      // original A[0][0] must still be issued
      run(2, -1, 0, 1'b0, 1'b0, '0, -1);

      bad_start(0);
      run(2, -1, 0, 1'b0, 1'b0, '0, -1);
      bad_start(5);
      run(2, -1, 0, 1'b0, 1'b0, '0, -1);

      // abort once slot 3 is visible
      run(4, -1, 0, 1'b0, 1'b0, '0, 4);
      run(3, -1, 0, 1'b0, 1'b0, '0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
